// File: rtl/conv_accumulator.sv
// conv_accumulator: sums TAPS signed products plus a bias per convolution
// window, then applies ReLU, round-half-up rescale by SHIFT and saturation
// into the 11-bit unsigned activation range.
module conv_accumulator #(
  parameter int TAPS  = 25,
  parameter int SHIFT = 10,
  parameter int ACC_W = 30
) (
  input  logic        cnn_clk,
  input  logic        cnn_rst,
  input  logic        clr,
  input  logic        prod_valid,
  input  logic [22:0] prod,
  input  logic [11:0] bias,
  output logic        busy,
  output logic        out_valid,
  output logic [11:0] dout,
  output logic        sat
);

  localparam int CNT_W = (TAPS > 2) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1 << (SHIFT - 1));
  localparam logic signed [ACC_W:0] ACT_MAX = (ACC_W+1)'(2047);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [11:0]             dout_q, dout_d;
  logic                    sat_q, sat_d;

  logic signed [ACC_W-1:0] prod_ext, bias_ext, sum;
  logic signed [ACC_W:0]   rnd, r_full;
  logic                    r_neg, r_big;

  // Final-beat datapath: sum, round half up, rescale and range compare in one cycle.
  // rnd carries one extra bit so adding the half-LSB constant cannot wrap.
  always_comb begin
    prod_ext = {{(ACC_W-23){prod[22]}}, prod};
    bias_ext = {{(ACC_W-12){bias[11]}}, bias} <<< SHIFT;
    sum      = acc_q + prod_ext;
    rnd      = {sum[ACC_W-1], sum} + HALF;
    r_full   = rnd >>> SHIFT;
    r_neg    = r_full[ACC_W];
    r_big    = !r_neg && (r_full > ACT_MAX);
  end

  // Window sequencing: clr aborts, first beat loads bias, final beat emits result.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tap_cnt_d   = tap_cnt_q;
    out_valid_d = 1'b0;
    dout_d      = dout_q;
    sat_d       = sat_q;
    if (clr) begin
      state_d   = IDLE;
      tap_cnt_d = '0;
    end else if (prod_valid) begin
      if (state_q == IDLE) begin
        acc_d     = bias_ext + prod_ext;
        tap_cnt_d = CNT_W'(1);
        state_d   = ACCUM;
      end else if (tap_cnt_q == LAST_TAP) begin
        acc_d       = sum;
        out_valid_d = 1'b1;
        sat_d       = r_big;
        dout_d      = r_neg ? 12'd0 : (r_big ? 12'd2047 : r_full[11:0]);
        state_d     = IDLE;
        tap_cnt_d   = '0;
      end else begin
        acc_d     = sum;
        tap_cnt_d = tap_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge cnn_clk or posedge cnn_rst) begin
    if (cnn_rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      tap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tap_cnt_q   <= tap_cnt_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
    end
  end

  assign busy      = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator with hand-computed expected results.
module tb_conv_accumulator;
  localparam int TAPS = 25;

  logic        cnn_clk = 1'b0;
  logic        cnn_rst = 1'b1;
  logic        clr = 1'b0;
  logic        prod_valid = 1'b0;
  logic [22:0] prod = '0;
  logic [11:0] bias = '0;
  logic        busy, out_valid, sat;
  logic [11:0] dout;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  conv_accumulator #(.TAPS(TAPS), .SHIFT(10), .ACC_W(30)) dut (
    .cnn_clk(cnn_clk), .cnn_rst(cnn_rst), .clr(clr), .prod_valid(prod_valid),
    .prod(prod), .bias(bias), .busy(busy), .out_valid(out_valid),
    .dout(dout), .sat(sat)
  );

  always #5 cnn_clk = ~cnn_clk;

  always @(negedge cnn_clk) if (out_valid) pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge cnn_clk);
    #1;
  endtask

  task automatic beat(input logic [22:0] p);
    prod_valid = 1'b1;
    prod = p;
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full window: first beat of pf, TAPS-2 more of pf, final beat pl.
  // Bias is scrambled after the first beat; only the first-tap value may count.
  task automatic window(input string tag, input logic [11:0] b, input logic [22:0] pf,
                        input logic [22:0] pl, input bit gaps, input int exp_d, input int exp_s);
    bias = b;
    for (int i = 0; i < TAPS - 1; i++) begin
      beat(pf);
      if (i == 0) begin
        bias = ~b;
        chk({tag, ".first_ov"}, int'(out_valid), 0);
      end
      if (gaps && (i % 3 == 1)) repeat (i % 4 + 1) tick();
    end
    chk({tag, ".busy"}, int'(busy), 1);
    beat(pl);
    chk({tag, ".ov"}, int'(out_valid), 1);
    chk({tag, ".dout"}, int'(dout), exp_d);
    chk({tag, ".sat"}, int'(sat), exp_s);
  endtask

  initial begin
    #1;
    chk("rst.ov", int'(out_valid), 0);
    chk("rst.dout", int'(dout), 0);
    chk("rst.sat", int'(sat), 0);
    chk("rst.busy", int'(busy), 0);
    tick();
    tick();
    cnn_rst = 1'b0;
    tick();

    // Nominal: 25 x 1024 -> 25
    window("nom", 12'd0, 23'd1024, 23'd1024, 1'b0, 25, 0);
    tick();
    chk("nom.pulse_once", int'(out_valid), 0);
    chk("nom.idle", int'(busy), 0);

    // Bias -5: 20480 -> 20
    window("bias", 12'hFFB, 23'd1024, 23'd1024, 1'b0, 20, 0);
    // Saturation: 25 x 2^21 -> r=51200
    window("satur", 12'd0, 23'h200000, 23'h200000, 1'b0, 2047, 1);
    // ReLU: 25 x -1024 -> 0, sat cleared
    window("relu", 12'd0, 23'h7FFC00, 23'h7FFC00, 1'b0, 0, 0);
    // Rounding
    window("rnd512", 12'd0, 23'd0, 23'd512, 1'b0, 1, 0);
    window("rnd511", 12'd0, 23'd0, 23'd511, 1'b0, 0, 0);
    window("rndm512", 12'd0, 23'd0, 23'h7FFE00, 1'b0, 0, 0);

    // Bubbles then back-to-back: A = 3072+51200 -> 53; B = 7168-2500 -> 5
    tick();
    pulses = 0;
    window("gapA", 12'd3, 23'd2048, 23'd2048, 1'b1, 53, 0);
    bias = 12'd7;
    beat(23'h7FFF9C);
    chk("b2b.ov_drop", int'(out_valid), 0);
    chk("b2b.hold", int'(dout), 53);
    chk("b2b.busy", int'(busy), 1);
    bias = 12'd0;
    for (int i = 0; i < TAPS - 2; i++) beat(23'h7FFF9C);
    beat(23'h7FFF9C);
    chk("gapB.ov", int'(out_valid), 1);
    chk("gapB.dout", int'(dout), 5);
    tick();
    chk("b2b.pulses", pulses, 2);

    // clr after 10 beats (clr also collides with a beat, which is dropped)
    pulses = 0;
    bias = 12'd1;
    for (int i = 0; i < 10; i++) beat(23'd1024);
    clr = 1'b1;
    beat(23'd1024);
    clr = 1'b0;
    chk("clr.busy", int'(busy), 0);
    chk("clr.ov", int'(out_valid), 0);
    // fresh window with bias 2: 27648 -> 27
    window("clr_next", 12'd2, 23'd1024, 23'd1024, 1'b0, 27, 0);
    tick();
    chk("clr.pulses", pulses, 1);

    // clr on the 25th beat: no pulse, outputs hold
    pulses = 0;
    bias = 12'd0;
    for (int i = 0; i < TAPS - 1; i++) beat(23'd1024);
    clr = 1'b1;
    beat(23'd1024);
    clr = 1'b0;
    chk("clrlast.ov", int'(out_valid), 0);
    chk("clrlast.hold", int'(dout), 27);
    chk("clrlast.busy", int'(busy), 0);
    tick();
    chk("clrlast.pulses", pulses, 0);

    // Reset after 12 beats: asynchronous clear
    for (int i = 0; i < 12; i++) beat(23'd1024);
    #2;
    cnn_rst = 1'b1;
    #1;
    chk("arst.dout", int'(dout), 0);
    chk("arst.busy", int'(busy), 0);
    chk("arst.ov", int'(out_valid), 0);
    tick();
    cnn_rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 13; i++) beat(23'd1024);
    chk("arst.no_pulse", pulses, 0);
    chk("arst.newwin", int'(busy), 1);
    for (int i = 0; i < 11; i++) beat(23'd1024);
    beat(23'd1024);
    chk("arst.fresh", int'(dout), 25);
    chk("arst.fresh_ov", int'(out_valid), 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
